// File: rtl/uart_hex_digit_rx.sv
// UART 8N1 receiver (8E1 when UART_HEX_RX_PARITY_EN is defined) that decodes ASCII hex to a toggle-strobe digit.
// Latency: outputs update 1 cycle after the stop-bit sample edge; there is no backpressure, and every frame is consumed.
module uart_hex_digit_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] digit_data,
    output logic       digit_strobe,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       char_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_HEX_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    logic        rx_meta;
    logic        rxs;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        done;
    logic        done_bad;
    logic        is_hex;
    logic [3:0]  hex_val;
`ifdef UART_HEX_RX_PARITY_EN
    logic        par_ok;
`endif

    // shift is not overwritten until the next frame's first data sample, so it can be decoded a cycle late
    always_comb begin
        is_hex  = 1'b0;
        hex_val = 4'd0;
        if (shift >= 8'h30 && shift <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = 4'(shift - 8'h30);
        end else if (shift >= 8'h41 && shift <= 8'h46) begin
            is_hex  = 1'b1;
            hex_val = 4'(shift - 8'h37);
        end else if (shift >= 8'h61 && shift <= 8'h66) begin
            is_hex  = 1'b1;
            hex_val = 4'(shift - 8'h57);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            state        <= S_IDLE;
            cnt          <= 16'd0;
            bit_idx      <= 3'd0;
            shift        <= 8'h00;
            done         <= 1'b0;
            done_bad     <= 1'b0;
            digit_data   <= 4'd0;
            digit_strobe <= 1'b0;
            rx_byte      <= 8'h00;
            frame_err    <= 1'b0;
            char_err     <= 1'b0;
`ifdef UART_HEX_RX_PARITY_EN
            par_ok       <= 1'b0;
`endif
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            done     <= 1'b0;
            done_bad <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        cnt   <= HALF_M1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (rxs) begin
                        state <= S_IDLE;
                    end else begin
                        cnt     <= FULL_M1;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shift   <= {rxs, shift[7:1]};
                        cnt     <= FULL_M1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_HEX_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_HEX_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        par_ok <= ~(^{rxs, shift});
                        cnt    <= FULL_M1;
                        state  <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        done <= 1'b1;
`ifdef UART_HEX_RX_PARITY_EN
                        done_bad <= !(rxs && par_ok);
`else
                        done_bad <= !rxs;
`endif
                        // a low stop bit may be a break; wait for the line to recover
                        state <= rxs ? S_IDLE : S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            frame_err <= done && done_bad;
            char_err  <= done && !done_bad && !is_hex;
            if (done) rx_byte <= shift;
            if (done && !done_bad && is_hex) begin
                digit_data   <= hex_val;
                digit_strobe <= ~digit_strobe;
            end
        end
    end

endmodule

// File: doc/uart_hex_digit_rx.md
# uart_hex_digit_rx

Serial-to-digit front end of the 7-segment display path. Receives 8N1 UART frames on a single RX line, decodes ASCII hex characters (`0`-`9`, `A`-`F`, `a`-`f`) to a 4-bit value, and publishes each valid digit on a toggle-strobe interface. The toggle-strobe interface drives the two-digit shift register that feeds the display: each level change of the strobe means one new digit. Non-hex characters and malformed frames are dropped and flagged.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range 8..65535.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous UART line, idle high.
- `digit_data`  output  4  last decoded hex value; held stable between strobe toggles.
- `digit_strobe`  output  1  toggles once per accepted digit (level change = new data).
- `rx_byte`  output  8  raw byte of the last completed frame, stored whether or not it is a valid hex character.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low (or parity fail, see Configuration).
- `char_err`  output  1  one-cycle pulse: frame good but byte not a hex character.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. Everything below uses the synchronized `rxs`.
- FSM states: IDLE, START, DATA, (PARITY), STOP, WAIT_IDLE.
- IDLE: when `rxs`=0, load the bit counter and go to START.
- START: after `CLKS_PER_BIT/2` cycles, sample `rxs`.
  - 0: go to DATA.
  - 1: glitch; return to IDLE with no output activity.
- DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, into a shift register. Go to STOP (or PARITY when the feature is compiled in).
- STOP: sample `CLKS_PER_BIT` cycles after the last data/parity sample.
  - 1: frame good. Load `rx_byte`, then decode:
    - `0x30`-`0x39` → value minus `0x30`.
    - `0x41`-`0x46` and `0x61`-`0x66` → 10-15.
    - Any other byte → `char_err`.
    - Return to IDLE.
  - 0: pulse `frame_err`, load `rx_byte`, emit no digit, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxs`=1, then IDLE. This prevents a break condition from being read as back-to-back frames.
- On an accepted digit, `digit_data` is loaded and `digit_strobe` inverted on the same edge. The consumer delays the strobe internally, so same-edge update is required, not a hazard.
- `frame_err` and `char_err` are never both high. Neither is ever high in the same cycle as a strobe toggle.

## Timing
- Reset values: `digit_data`=0, `digit_strobe`=0, `rx_byte`=0x00, `frame_err`=0, `char_err`=0. FSM is in IDLE and counters are 0.
- `rst` asserted mid-frame aborts the frame with no output change other than the reset values. The first frame after reset is received normally.
- Latency: the strobe toggle occurs exactly 1 cycle after the stop-bit sample edge. The stop-bit sample edge is 2 (synchronizer) + 1 (IDLE detect) + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` cycles after the falling edge of `rx`. Add `CLKS_PER_BIT` with parity.
- The error pulses (`frame_err`, `char_err`) have the same latency as the strobe and are exactly 1 cycle wide.
- Back-to-back frames: a start bit that begins immediately after the stop-bit midpoint is detected. There is no dead time beyond the IDLE detect cycle.
- `CLKS_PER_BIT` is odd: the half-bit delay is `CLKS_PER_BIT/2`, truncated.
- The bit counter is 16 bits and never wraps within a frame.

## Configuration
- `UART_HEX_RX_PARITY_EN` defined:
  - Frame is 8E1.
  - A PARITY state samples a ninth bit `CLKS_PER_BIT` after bit 7.
  - Even parity is checked across the 8 data bits plus the parity bit.
  - On mismatch, the stop bit is still sampled. The frame is then dropped with a `frame_err` pulse at stop-sample latency, `rx_byte` is still loaded, and there is no `char_err`.
- Undefined: 8N1, no PARITY state, and the parity logic is absent.

## Test plan
- `CLKS_PER_BIT`=16, after reset send `0x37` ('7') → `digit_data`=7, `digit_strobe` 0→1 at the specified latency, `rx_byte`=0x37, no error pulses.
- Send `'A'` then `'f'` back-to-back with no idle gap → `digit_data`=0xA with strobe 1→0, then 0xF with strobe 0→1; exactly two toggles.
- Send `0x47` ('G') → one-cycle `char_err`, `rx_byte`=0x47, `digit_data` and `digit_strobe` unchanged.
- Send `0x35` with the stop bit forced 0, hold `rx` low for 40 cycles, then release high → single `frame_err` pulse, no strobe toggle. A following `'3'` yields `digit_data`=3.
- Drive a 4-cycle low glitch on idle `rx` → no state change reaches any output.
- Assert `rst` for 1 cycle during bit 4 of `'9'`, then send `'2'` → all outputs return to their reset values, then `digit_data`=2 with `digit_strobe`=1.
  - With `UART_HEX_RX_PARITY_EN`: `'5'` with wrong parity → `frame_err`, no toggle.
